// File: rtl/sample_framer_pkg.sv
// Shared definitions for the sample framer: default geometry, frame counter width
// and the classification of an accepted sample.
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif
`ifndef INPUT_CHANNELS
`define INPUT_CHANNELS 4
`endif

package sample_framer_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_START,
    ACT_STORE,
    ACT_DROP
  } sample_act_e;

  // A first-flagged sample always restarts the frame; an unflagged one at channel 0 is orphaned.
  function automatic sample_act_e classify(input logic accept, input logic first, input logic at_ch0);
    if (!accept)      return ACT_NONE;
    else if (first)   return ACT_START;
    else if (at_ch0)  return ACT_DROP;
    else              return ACT_STORE;
  endfunction

endpackage

// File: rtl/frame_fifo2.sv
// Two-entry flop-based frame FIFO; head is presented directly from a register.
// Push is ignored when full unless a pop happens in the same cycle.
module frame_fifo2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic             full_o,
  output logic [WIDTH-1:0] dat_o
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_dat_i;
        else               tail_d = push_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; with a single entry the pushed frame becomes the head.
        if (cnt_q == 2'd1) begin
          head_d = push_dat_i;
        end else begin
          head_d = tail_q;
          tail_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign vld_o  = (cnt_q != 2'd0);
  assign full_o = (cnt_q == 2'd2);
  assign dat_o  = head_q;

endmodule

// File: rtl/sample_framer.sv
// Collects INPUT_CHANNELS per-channel samples into one frame, buffers up to two frames
// and flags framing errors; frame output appears the cycle after the last sample.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH  = `CHANNEL_WIDTH,
  parameter int unsigned INPUT_CHANNELS = `INPUT_CHANNELS
) (
  input  logic                                  Clk_CI,
  input  logic                                  Reset_RI,
  input  logic                                  SampleValid_SI,
  output logic                                  SampleReady_SO,
  input  logic                                  SampleFirst_SI,
  input  logic [CHANNEL_WIDTH-1:0]              Sample_DI,
  output logic                                  ValidOut_SO,
  input  logic                                  ReadyIn_SI,
  output logic [0:CHANNEL_WIDTH*INPUT_CHANNELS-1] Raw_DO,
  output logic                                  SyncErr_SO,
  output logic [FRAME_CNT_W-1:0]                FrameCount_DO
);

  localparam int unsigned FRAME_W = CHANNEL_WIDTH * INPUT_CHANNELS;
  localparam int unsigned CNT_W   = $clog2(INPUT_CHANNELS);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(INPUT_CHANNELS - 1);

  logic [CNT_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [0:FRAME_W-1]     frame_q, frame_d;
  logic                   sync_err_q, sync_err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   fifo_full, fifo_vld;
  logic                   accept, push, pop;
  sample_act_e            act;

  // Stall only when the frame about to complete would have nowhere to go.
  assign SampleReady_SO = !((ch_cnt_q == LAST_CH) && fifo_full);
  assign accept         = SampleValid_SI && SampleReady_SO;
  assign act            = classify(accept, SampleFirst_SI, ch_cnt_q == '0);
  assign pop            = fifo_vld && ReadyIn_SI;

  always_comb begin
    ch_cnt_d   = ch_cnt_q;
    frame_d    = frame_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    case (act)
      ACT_START: begin
        frame_d[0 +: CHANNEL_WIDTH] = Sample_DI;
        ch_cnt_d   = CNT_W'(1);
        sync_err_d = (ch_cnt_q != '0);
      end
      ACT_STORE: begin
        frame_d[int'(ch_cnt_q) * CHANNEL_WIDTH +: CHANNEL_WIDTH] = Sample_DI;
        if (ch_cnt_q == LAST_CH) begin
          push     = 1'b1;
          ch_cnt_d = '0;
        end else begin
          ch_cnt_d = ch_cnt_q + 1'b1;
        end
      end
      ACT_DROP: sync_err_d = 1'b1;
      default: ;
    endcase
  end

  assign frame_cnt_d = pop ? frame_cnt_q + 1'b1 : frame_cnt_q;

  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      ch_cnt_q    <= '0;
      frame_q     <= '0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      frame_q     <= frame_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // frame_d already carries the last-channel sample when push is asserted.
  frame_fifo2 #(
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk_i      (Clk_CI),
    .rst_ni     (Reset_RI),
    .push_i     (push),
    .push_dat_i (frame_d),
    .pop_i      (pop),
    .vld_o      (fifo_vld),
    .full_o     (fifo_full),
    .dat_o      (Raw_DO)
  );

  assign ValidOut_SO   = fifo_vld;
  assign SyncErr_SO    = sync_err_q;
  assign FrameCount_DO = frame_cnt_q;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with 8-bit channels and 4 channels per frame.
module tb_sample_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SampleValid_SI, SampleFirst_SI, ReadyIn_SI;
  logic [7:0]  Sample_DI;
  logic        SampleReady_SO, ValidOut_SO, SyncErr_SO;
  logic [0:31] Raw_DO;
  logic [15:0] FrameCount_DO;

  int n_chk  = 0;
  int n_pass = 0;
  int err_cnt = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  sample_framer #(
    .CHANNEL_WIDTH  (8),
    .INPUT_CHANNELS (4)
  ) dut (
    .Clk_CI         (clk),
    .Reset_RI       (rst_n),
    .SampleValid_SI (SampleValid_SI),
    .SampleReady_SO (SampleReady_SO),
    .SampleFirst_SI (SampleFirst_SI),
    .Sample_DI      (Sample_DI),
    .ValidOut_SO    (ValidOut_SO),
    .ReadyIn_SI     (ReadyIn_SI),
    .Raw_DO         (Raw_DO),
    .SyncErr_SO     (SyncErr_SO),
    .FrameCount_DO  (FrameCount_DO)
  );

  // Handshakes and error pulses are observed just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (ValidOut_SO && ReadyIn_SI) got_q.push_back(Raw_DO);
    if (SyncErr_SO) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    int n = 0;
    @(negedge clk);
    SampleValid_SI = 1'b1;
    Sample_DI      = d;
    SampleFirst_SI = f;
    while (!SampleReady_SO && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_ready_timeout", {31'd0, SampleReady_SO}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f);
    send(f[31:24], 1'b1);
    send(f[23:16], 1'b0);
    send(f[15:8],  1'b0);
    send(f[7:0],   1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    SampleValid_SI = 1'b0;
    SampleFirst_SI = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    SampleValid_SI = 1'b0;
    SampleFirst_SI = 1'b0;
    Sample_DI = 8'h00;
    ReadyIn_SI = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, ValidOut_SO}, 32'd0);
    check("rst_syncerr", {31'd0, SyncErr_SO}, 32'd0);
    check("rst_count", {16'd0, FrameCount_DO}, 32'd0);
    check("rst_raw", Raw_DO, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, SampleReady_SO}, 32'd1);

    // Basic frame, one cycle latency
    send_frame(32'h11223344);
    idle();
    check("basic_valid", {31'd0, ValidOut_SO}, 32'd1);
    check("basic_raw", Raw_DO, 32'h11223344);
    @(negedge clk);
    check("basic_count", {16'd0, FrameCount_DO}, 32'd1);
    check("basic_drained", {31'd0, ValidOut_SO}, 32'd0);

    // Orphan sample without first flag
    got_q.delete();
    err_cnt = 0;
    send(8'h55, 1'b0);
    idle();
    check("orphan_err", {31'd0, SyncErr_SO}, 32'd1);
    check("orphan_novalid", {31'd0, ValidOut_SO}, 32'd0);
    @(negedge clk);
    check("orphan_err_pulse", {31'd0, SyncErr_SO}, 32'd0);
    repeat (3) @(negedge clk);
    check("orphan_err_cnt", err_cnt, 32'd1);
    check("orphan_no_frame", got_q.size(), 32'd0);

    // Partial frame restarted by a new first sample
    got_q.delete();
    err_cnt = 0;
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    send_frame(32'h11223344);
    idle();
    repeat (5) @(negedge clk);
    check("resync_err_cnt", err_cnt, 32'd1);
    check("resync_nframes", got_q.size(), 32'd1);
    check("resync_frame", got_q[0], 32'h11223344);

    // Backpressure: two frames buffered, third stalls on its last sample
    got_q.delete();
    @(negedge clk);
    ReadyIn_SI = 1'b0;
    send_frame(32'h01020304);
    send_frame(32'h05060708);
    send(8'h09, 1'b1);
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    @(negedge clk);
    Sample_DI = 8'h0C;
    SampleFirst_SI = 1'b0;
    check("bp_ready_low", {31'd0, SampleReady_SO}, 32'd0);
    check("bp_valid", {31'd0, ValidOut_SO}, 32'd1);
    check("bp_head", Raw_DO, 32'h01020304);
    repeat (3) @(negedge clk);
    check("bp_still_low", {31'd0, SampleReady_SO}, 32'd0);
    check("bp_head_stable", Raw_DO, 32'h01020304);
    ReadyIn_SI = 1'b1;
    begin
      int n = 0;
      while (!SampleReady_SO && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    idle();
    repeat (8) @(negedge clk);
    check("bp_nframes", got_q.size(), 32'd3);
    check("bp_frame0", got_q[0], 32'h01020304);
    check("bp_frame1", got_q[1], 32'h05060708);
    check("bp_frame2", got_q[2], 32'h090A0B0C);
    check("bp_count", {16'd0, FrameCount_DO}, 32'd5);

    // Push and pop in the same cycle with one entry held
    got_q.delete();
    ReadyIn_SI = 1'b0;
    send_frame(32'h21222324);
    send(8'h31, 1'b1);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    @(negedge clk);
    Sample_DI = 8'h34;
    SampleFirst_SI = 1'b0;
    ReadyIn_SI = 1'b1;
    @(posedge clk);
    idle();
    ReadyIn_SI = 1'b0;
    check("simul_valid", {31'd0, ValidOut_SO}, 32'd1);
    check("simul_head", Raw_DO, 32'h31323334);
    ReadyIn_SI = 1'b1;
    repeat (4) @(negedge clk);
    check("simul_nframes", got_q.size(), 32'd2);
    check("simul_order", got_q[0], 32'h21222324);
    check("simul_count", {16'd0, FrameCount_DO}, 32'd7);

    // Asynchronous reset with one frame buffered and a partial frame in flight
    ReadyIn_SI = 1'b0;
    send_frame(32'hC1C2C3C4);
    send(8'hD1, 1'b1);
    send(8'hD2, 1'b0);
    idle();
    check("prerst_valid", {31'd0, ValidOut_SO}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ValidOut_SO}, 32'd0);
    check("arst_raw", Raw_DO, 32'd0);
    check("arst_count", {16'd0, FrameCount_DO}, 32'd0);
    check("arst_syncerr", {31'd0, SyncErr_SO}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ReadyIn_SI = 1'b1;
    got_q.delete();
    err_cnt = 0;
    check("arst_ready", {31'd0, SampleReady_SO}, 32'd1);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b0);
    send_frame(32'hE1E2E3E4);
    idle();
    repeat (5) @(negedge clk);
    check("arst_err_cnt", err_cnt, 32'd2);
    check("arst_nframes", got_q.size(), 32'd1);
    check("arst_frame", got_q[0], 32'hE1E2E3E4);
    check("arst_count_after", {16'd0, FrameCount_DO}, 32'd1);

    // Frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("wrap_preload", {16'd0, FrameCount_DO}, 32'h0000FFFF);
    send_frame(32'h5A5B5C5D);
    idle();
    repeat (3) @(negedge clk);
    check("wrap_count", {16'd0, FrameCount_DO}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
